// File: rtl/subtrator_demux_if.sv
// Bus bundle for subtrator_demux: operand/request side driven by the master,
// decoded results and status returned by the slave (the checker).
interface subtrator_demux_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] RES;
  logic             clr_cnt;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             S_dec;
  logic             ambig;
  logic             err;
  logic [3:0]       err_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output start, A, B, C, RES, clr_cnt,
    input  ready, done, diff, S_dec, ambig, err, err_cnt, dbg_state
  );

  modport slave (
    input  start, A, B, C, RES, clr_cnt,
    output ready, done, diff, S_dec, ambig, err, err_cnt, dbg_state
  );
endinterface

// File: rtl/subtrator_demux.sv
// Inverse checker for the mux+adder datapath: recovers RES - A, decodes which
// mux input produced it, flags mismatches and counts them (saturating).
module subtrator_demux #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  subtrator_demux_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, CMP = 2'd2, DONE = 2'd3} state_t;

  state_t state, state_next;
  logic   capture;

  logic [WIDTH-1:0] a_r, b_r, c_r, res_r, diff_r;
  logic [WIDTH-1:0] diff_q;
  logic             s_dec_q, ambig_q, err_q;
  logic [3:0]       err_cnt_q;
  logic             eq_b, eq_c, err_new;

  // Handshake: a request is accepted on any rising edge where start=1 and
  // ready=1 (IDLE only); done is a one-cycle pulse marking fresh results,
  // which then hold until the next completed operation.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          state_next = SUB;
        end
      end
      SUB:     state_next = CMP;
      CMP:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign eq_b    = (diff_r == b_r);
  assign eq_c    = (diff_r == c_r);
  assign err_new = ~eq_b & ~eq_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      res_r     <= '0;
      diff_r    <= '0;
      diff_q    <= '0;
      s_dec_q   <= 1'b0;
      ambig_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 4'd0;
    end else begin
      if (capture) begin
        a_r   <= bus.A;
        b_r   <= bus.B;
        c_r   <= bus.C;
        res_r <= bus.RES;
      end
      if (state == SUB) diff_r <= res_r - a_r;
      if (state == CMP) begin
        diff_q  <= diff_r;
        s_dec_q <= eq_b;
        ambig_q <= eq_b & eq_c;
        err_q   <= err_new;
      end
      // Clear beats a same-edge increment so software never loses a clear.
      if (bus.clr_cnt)
        err_cnt_q <= 4'd0;
      else if (state == CMP && err_new && err_cnt_q != 4'd15)
        err_cnt_q <= err_cnt_q + 4'd1;
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.S_dec     = s_dec_q;
  assign bus.ambig     = ambig_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.dbg_state = state;

endmodule
